// File: rtl/wb_arbiter_2m_pkg.sv
// rtl/wb_arbiter_2m_pkg.sv - shared owner-state type and default bus widths for the two-master arbiter
package wb_arbiter_2m_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    M0   = 2'd1,
    M1   = 2'd2
  } owner_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;

endpackage

// File: rtl/wb_arbiter_2m_if.sv
// rtl/wb_arbiter_2m_if.sv - Wishbone classic point-to-point link with master/slave modports
interface wb_arbiter_2m_if
  import wb_arbiter_2m_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic                  we;
  logic                  stb;
  logic                  cyc;
  logic [SEL_WIDTH-1:0]  sel;
  logic [DATA_WIDTH-1:0] wdat;
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] rdat;
  logic                  ack;
  logic                  intr;

  // wishbone "int" is a keyword, so the interrupt line is named intr
  modport master (
    output we, stb, cyc, sel, wdat, adr,
    input  rdat, ack, intr
  );

  modport slave (
    input  we, stb, cyc, sel, wdat, adr,
    output rdat, ack, intr
  );

endinterface

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master Wishbone classic arbiter; master 0 wins ties, grant held for the whole cyc
module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  wb_arbiter_2m_if.slave  m0,
  wb_arbiter_2m_if.slave  m1,
  wb_arbiter_2m_if.master s
);

  localparam logic [DATA_WIDTH-1:0]   DAT_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0]   ADR_ZERO = '0;
  localparam logic [DATA_WIDTH/8-1:0] SEL_ZERO = '0;

  owner_t state_q;
  owner_t state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // On release the other master is granted at the same edge, so no idle gap
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0.cyc)      state_d = M0;
        else if (m1.cyc) state_d = M1;
        else             state_d = IDLE;
      end
      M0: begin
        if (m0.cyc)      state_d = M0;
        else if (m1.cyc) state_d = M1;
        else             state_d = IDLE;
      end
      M1: begin
        if (m1.cyc)      state_d = M1;
        else if (m0.cyc) state_d = M0;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s.we    = 1'b0;
    s.stb   = 1'b0;
    s.cyc   = 1'b0;
    s.sel   = SEL_ZERO;
    s.wdat  = DAT_ZERO;
    s.adr   = ADR_ZERO;
    m0.ack  = 1'b0;
    m0.rdat = DAT_ZERO;
    m1.ack  = 1'b0;
    m1.rdat = DAT_ZERO;
    case (state_q)
      M0: begin
        s.we    = m0.we;
        s.stb   = m0.stb;
        s.cyc   = m0.cyc;
        s.sel   = m0.sel;
        s.wdat  = m0.wdat;
        s.adr   = m0.adr;
        m0.ack  = s.ack;
        m0.rdat = s.rdat;
      end
      M1: begin
        s.we    = m1.we;
        s.stb   = m1.stb;
        s.cyc   = m1.cyc;
        s.sel   = m1.sel;
        s.wdat  = m1.wdat;
        s.adr   = m1.adr;
        m1.ack  = s.ack;
        m1.rdat = s.rdat;
      end
      default: ;
    endcase
  end

  // interrupts bypass arbitration and reset
  assign m0.intr = s.intr;
  assign m1.intr = s.intr;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - directed and randomized checks of wb_arbiter_2m against a grant-rule model
module tb_wb_arbiter_2m;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter_2m_if bm0 ();
  wb_arbiter_2m_if bm1 ();
  wb_arbiter_2m_if bs ();

  wb_arbiter_2m dut (
    .clk (clk),
    .rst (rst),
    .m0  (bm0),
    .m1  (bm1),
    .s   (bs)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model owner: 0 = nobody, 1 = master 0, 2 = master 1
  int m_owner = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // owner keeps the bus while it holds cyc; otherwise lowest-numbered requester wins
  always @(posedge clk or negedge rst) begin
    logic [1:0] req;
    if (!rst) begin
      m_owner <= 0;
    end else begin
      req = {bm1.cyc, bm0.cyc};
      if (m_owner != 0 && req[m_owner-1]) m_owner <= m_owner;
      else if (req[0])                    m_owner <= 1;
      else if (req[1])                    m_owner <= 2;
      else                                m_owner <= 0;
    end
  end

  always @(negedge clk) begin
    logic [70:0] req [2];
    logic [70:0] exp_req;
    req[0] = {bm0.we, bm0.stb, bm0.cyc, bm0.sel, bm0.wdat, bm0.adr};
    req[1] = {bm1.we, bm1.stb, bm1.cyc, bm1.sel, bm1.wdat, bm1.adr};
    exp_req = (m_owner == 0) ? '0 : req[m_owner-1];
    chk("s_req", {bs.we, bs.stb, bs.cyc, bs.sel, bs.wdat, bs.adr}, exp_req);
    chk("m0_ack", bm0.ack, (m_owner == 1) & bs.ack);
    chk("m1_ack", bm1.ack, (m_owner == 2) & bs.ack);
    chk("m0_rdat", bm0.rdat, (m_owner == 1) ? bs.rdat : 32'h0);
    chk("m1_rdat", bm1.rdat, (m_owner == 2) ? bs.rdat : 32'h0);
    chk("m0_int", bm0.intr, bs.intr);
    chk("m1_int", bm1.intr, bs.intr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_m0();
    bm0.we = 0; bm0.stb = 0; bm0.cyc = 0; bm0.sel = '0; bm0.wdat = '0; bm0.adr = '0;
  endtask

  task automatic idle_m1();
    bm1.we = 0; bm1.stb = 0; bm1.cyc = 0; bm1.sel = '0; bm1.wdat = '0; bm1.adr = '0;
  endtask

  initial begin
    idle_m0();
    idle_m1();
    bs.rdat = '0; bs.ack = 0; bs.intr = 0;

    // reset state and interrupt passthrough
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_s_cyc", bs.cyc, 1'b0);
    chk("rst_s_adr", bs.adr, 32'h0);
    chk("rst_m0_ack", bm0.ack, 1'b0);
    chk("rst_m1_ack", bm1.ack, 1'b0);
    bs.intr = 1;
    #1;
    chk("int_m0", bm0.intr, 1'b1);
    chk("int_m1", bm1.intr, 1'b1);
    bs.intr = 0;

    // master 0 single write, slave acks one cycle after the grant
    bm0.cyc = 1; bm0.stb = 1; bm0.we = 1; bm0.sel = 4'hf; bm0.adr = 32'h10; bm0.wdat = 32'hdeadbeef;
    #1;
    chk("grant_latency_cyc", bs.cyc, 1'b0);
    tick();
    chk("m0w_adr", bs.adr, 32'h10);
    chk("m0w_dat", bs.wdat, 32'hdeadbeef);
    chk("m0w_we", bs.we, 1'b1);
    bs.ack = 1;
    #1;
    chk("m0w_ack", bm0.ack, 1'b1);
    chk("m0w_m1_ack", bm1.ack, 1'b0);
    tick();
    bs.ack = 0;
    idle_m0();
    tick();

    // simultaneous request: master 0 first, then master 1 reads 0x4
    bm0.cyc = 1; bm0.stb = 1; bm0.we = 0; bm0.adr = 32'h20; bm0.sel = 4'hf;
    bm1.cyc = 1; bm1.stb = 1; bm1.we = 0; bm1.adr = 32'h4;  bm1.sel = 4'hf;
    tick();
    chk("model_tie_owner", m_owner, 1);
    chk("tie_adr", bs.adr, 32'h20);
    bs.ack = 1; bs.rdat = 32'h12345678;
    #1;
    chk("tie_m1_stall_ack", bm1.ack, 1'b0);
    chk("tie_m1_stall_dat", bm1.rdat, 32'h0);
    tick();
    bs.ack = 0;
    idle_m0();
    #1;
    chk("release_cyc_comb", bs.cyc, 1'b0);
    tick();
    chk("handover_adr", bs.adr, 32'h4);
    bs.ack = 1;
    #1;
    chk("m1r_dat", bm1.rdat, 32'h12345678);
    chk("m1r_ack", bm1.ack, 1'b1);
    tick();
    bs.ack = 0;
    idle_m1();
    tick();

    // master 1 four-beat cycle is not split by a master 0 request
    bm1.cyc = 1; bm1.stb = 1; bm1.we = 1; bm1.adr = 32'h100; bm1.sel = 4'h3;
    tick();
    for (int b = 0; b < 4; b++) begin
      bs.ack = 1; bm1.wdat = 32'h1000 + b;
      #1;
      chk("burst_m1_ack", bm1.ack, 1'b1);
      chk("burst_m0_ack", bm0.ack, 1'b0);
      chk("burst_adr", bs.adr, 32'h100);
      if (b == 0) begin
        bm0.cyc = 1; bm0.stb = 1; bm0.adr = 32'h200;
      end
      tick();
      bm1.adr = bm1.adr + 4;
      bm1.adr = 32'h100;
    end
    bs.ack = 0;
    idle_m1();
    tick();
    chk("after_burst_adr", bs.adr, 32'h200);
    chk("model_after_burst", m_owner, 1);

    // asynchronous reset while master 0 has stb up and is being acked
    bs.ack = 1; bs.intr = 1;
    #1;
    chk("pre_rst_ack", bm0.ack, 1'b1);
    rst = 0;
    #1;
    chk("rst_mid_cyc", bs.cyc, 1'b0);
    chk("rst_mid_stb", bs.stb, 1'b0);
    chk("rst_mid_ack", bm0.ack, 1'b0);
    chk("rst_mid_int", bm0.intr, 1'b1);
    tick();
    rst = 1;
    #1;
    chk("rearb_wait", bs.cyc, 1'b0);
    tick();
    chk("rearb_grant", bs.cyc, 1'b1);
    bs.ack = 0; bs.intr = 0;
    idle_m0();
    tick();

    // randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      if (bm0.cyc) begin
        if ($urandom_range(3) == 0) bm0.cyc = 0;
      end else if ($urandom_range(2) == 0) begin
        bm0.cyc = 1;
      end
      if (bm1.cyc) begin
        if ($urandom_range(3) == 0) bm1.cyc = 0;
      end else if ($urandom_range(2) == 0) begin
        bm1.cyc = 1;
      end
      bm0.stb = bm0.cyc & $urandom_range(1);
      bm1.stb = bm1.cyc & $urandom_range(1);
      bm0.we = 1'($urandom); bm0.sel = 4'($urandom); bm0.wdat = $urandom; bm0.adr = $urandom;
      bm1.we = 1'($urandom); bm1.sel = 4'($urandom); bm1.wdat = $urandom; bm1.adr = $urandom;
      bs.ack = 1'($urandom); bs.rdat = $urandom; bs.intr = 1'($urandom);
      if ($urandom_range(99) == 0) begin
        #1 rst = 0;
        tick();
        rst = 1;
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master, one-slave Wishbone classic arbiter. It places a host-side memory path (master 0) and a peripheral DMA/bus-master path (master 1) in front of a single memory slave, such as the test block RAM. Ownership is granted per bus cycle (`cyc`) and held until the owner releases it. The granted master's request is muxed to the slave, and the slave's response is routed back to that master only.

## Interface
- `DATA_WIDTH`, default 32: data bus width; select width is `DATA_WIDTH/8`.
- `ADDR_WIDTH`, default 32: address bus width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `i_m0_we`, `i_m0_stb`, `i_m0_cyc` in 1 each: master 0 request controls.
- `i_m0_sel` in `DATA_WIDTH/8`: master 0 byte selects.
- `i_m0_dat` in `DATA_WIDTH`: master 0 write data.
- `i_m0_adr` in `ADDR_WIDTH`: master 0 address.
- `o_m0_dat` out `DATA_WIDTH`: read data to master 0.
- `o_m0_ack` out 1: acknowledge to master 0.
- `o_m0_int` out 1: interrupt to master 0.
- `i_m1_*` / `o_m1_*`: identical set for master 1.
- `o_s_we`, `o_s_stb`, `o_s_cyc` out 1 each; `o_s_sel` out `DATA_WIDTH/8`; `o_s_dat` out `DATA_WIDTH`; `o_s_adr` out `ADDR_WIDTH`: request to the slave.
- `i_s_dat` in `DATA_WIDTH`, `i_s_ack` in 1, `i_s_int` in 1: slave response.

## Operation
- Registered owner state: `IDLE`, `M0`, `M1`. Reset value is `IDLE`.
- From `IDLE`:
  - If `i_m0_cyc` is high, go to `M0`. Master 0 has fixed priority when both request in the same cycle.
  - Else if `i_m1_cyc` is high, go to `M1`.
  - Else stay in `IDLE`.
- In `M0`: stay while `i_m0_cyc` is high. When it is low, go to `M1` if `i_m1_cyc` is high, else go to `IDLE`.
- In `M1`: symmetric to `M0`; on release, hand over to master 0 if it is requesting.
- Slave request outputs (`o_s_we/stb/cyc/sel/dat/adr`) are a combinational mux of the owner's inputs. In `IDLE` all of them are 0.
- The owner's `o_mX_ack` equals `i_s_ack` and its `o_mX_dat` equals `i_s_dat`. The non-owner sees `ack=0` and `dat=0`, so it stalls until granted.
- `i_s_int` is forwarded combinationally to both `o_m0_int` and `o_m1_int` regardless of ownership.
- Grant never changes while the owner holds `cyc`. Bursts and multi-beat cycles are never split.
- The arbiter does not decode addresses or buffer data.

## Timing
- Grant latency: `cyc` asserted at edge N gives the owner state at edge N+1. The slave sees `stb`/`cyc` in the cycle after the request appears.
- A master must hold `stb`/`cyc` until it sees `ack`. Standard Wishbone classic rules apply.
- Release: when the owner drops `cyc`, `o_s_cyc` drops in the same cycle (combinational). The state changes at the next edge.
- Handover to a waiting master takes no idle cycle: that master is granted at the release edge.
- Simultaneous release by the owner and request by the other master: the other master is granted at that edge.
- Reset mid-transfer: all `o_s_*`, `o_m*_ack` and `o_m*_dat` go to 0 immediately (asynchronously). `o_m*_int` still follows `i_s_int`. The state returns to `IDLE`. After reset deasserts, arbitration restarts from `IDLE` priority.
- A slave `ack` arriving in `IDLE` is dropped (goes to neither master).

## Structure
- Shared package holds:
  - an owner-state enum (`IDLE`, `M0`, `M1`, 2-bit encoding);
  - the default width constants (32/32).
- No sub-module is needed: one state register plus a combinational mux/demux.

## Test plan
- Reset: drive `rst=0`, then release → all `o_s_*` are 0 and both acks are 0. Then `i_s_int=1` → both `o_m*_int` are 1.
- Master 0 alone writes `0xDEADBEEF` to `adr 0x10`; the slave acks one cycle later → `o_s_adr=0x10`, `o_s_dat=0xDEADBEEF`, `o_m0_ack` pulses, `o_m1_ack` stays 0.
- Both masters raise `cyc` in the same cycle → master 0 is granted first. Master 1 sees no ack until master 0 drops `cyc`, then is granted at the next edge. A master 1 read of `adr 0x4` returns the slave data `0x12345678` on `o_m1_dat`.
- Master 1 holds a 4-beat cycle while master 0 requests after beat 1 → all 4 beats complete on master 1 before master 0 is granted.
- Assert `rst` low while master 0 owns the bus with `stb` high → `o_s_cyc`, `o_s_stb` and `o_m0_ack` are 0 immediately. After release, master 0 must re-arbitrate (one-cycle grant latency).
